slot_reel_judge: RTL and testbench

Downstream consumer of the 4-bit LFSR slot stage. It gates that stage's `running` input, captures three successive LFSR values as reels on stop-button edges, scores the result, and maintains a saturating credit counter. It sits between the board buttons/coin input and the display/LED logic, and owns the game's round sequencing.

---
 rtl/slot_pkg.sv | 37 +++
 rtl/slot_reel_judge_if.sv | 30 +++
 rtl/slot_btn_edge.sv | 66 ++++++
 rtl/slot_reel_judge.sv | 169 ++++++++++++++++
 tb/tb_slot_reel_judge.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/slot_pkg.sv
// Shared types and defaults for the slot reel judge: FSM states, reel type, scoring helper.
package slot_pkg;

    typedef logic [3:0] reel_t;

    typedef enum logic [2:0] {
        StIdle,
        StSpin0,
        StSpin1,
        StSpin2,
        StJudge,
        StShow
    } state_e;

    typedef enum logic [1:0] {
        ScoreNone,
        ScorePair,
        ScoreJackpot
    } score_e;

    localparam int unsigned DEFAULT_CREDIT_W       = 8;
    localparam int unsigned DEFAULT_INIT_CREDITS   = 3;
    localparam int unsigned DEFAULT_PAYOUT_PAIR    = 2;
    localparam int unsigned DEFAULT_PAYOUT_JACKPOT = 10;

    // Jackpot takes precedence, so a pair is "exactly two equal".
    function automatic score_e score_reels(reel_t a, reel_t b, reel_t c);
        if (a == b && b == c) begin
            return ScoreJackpot;
        end
        if (a == b || b == c || a == c) begin
            return ScorePair;
        end
        return ScoreNone;
    endfunction

endpackage

// File: rtl/slot_reel_judge_if.sv
// Button/LFSR inputs and reel/score/credit outputs of the slot reel judge.
interface slot_reel_judge_if #(
    parameter int unsigned CREDIT_W = 8
);
    import slot_pkg::*;

    reel_t               lfsr_in;
    logic                start_btn;
    logic                stop_btn;
    logic                coin;
    logic                running;
    reel_t               reel0;
    reel_t               reel1;
    reel_t               reel2;
    logic [2:0]          reel_valid;
    logic                win;
    logic                jackpot;
    logic [CREDIT_W-1:0] credits;

    modport master (
        output lfsr_in, start_btn, stop_btn, coin,
        input  running, reel0, reel1, reel2, reel_valid, win, jackpot, credits
    );

    modport slave (
        input  lfsr_in, start_btn, stop_btn, coin,
        output running, reel0, reel1, reel2, reel_valid, win, jackpot, credits
    );

endinterface

// File: rtl/slot_btn_edge.sv
// Button conditioner: optional stability filter (SLOT_JUDGE_DEBOUNCE_EN) then a
// one-cycle rising-edge pulse taken on the conditioned level.
module slot_btn_edge #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic level,
    output logic rise
);

`ifdef SLOT_JUDGE_DEBOUNCE_EN
    localparam bit FILTER_EN = 1'b1;
`else
    localparam bit FILTER_EN = 1'b0;
`endif
    localparam int unsigned FILTER_LEN = FILTER_EN ? DEBOUNCE_CYCLES : 0;

    logic filtered;
    logic prev_q;

    if (FILTER_LEN > 0) begin : g_filter
        localparam int unsigned CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             stable_q, stable_d;

        // Counter restarts whenever the raw level agrees with the filtered one.
        always_comb begin
            cnt_d    = '0;
            stable_d = stable_q;
            if (level != stable_q) begin
                if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
                    stable_d = level;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                cnt_q    <= '0;
                stable_q <= 1'b0;
            end else begin
                cnt_q    <= cnt_d;
                stable_q <= stable_d;
            end
        end

        assign filtered = stable_q;
    end else begin : g_raw
        assign filtered = level;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= filtered;
        end
    end

    assign rise = filtered & ~prev_q;

endmodule

// File: rtl/slot_reel_judge.sv
// Slot round sequencer: gates the LFSR, captures three reels, scores them and keeps
// a saturating credit balance. Optional button debounce via SLOT_JUDGE_DEBOUNCE_EN.
module slot_reel_judge #(
    parameter int unsigned CREDIT_W        = slot_pkg::DEFAULT_CREDIT_W,
    parameter int unsigned INIT_CREDITS    = slot_pkg::DEFAULT_INIT_CREDITS,
    parameter int unsigned PAYOUT_PAIR     = slot_pkg::DEFAULT_PAYOUT_PAIR,
    parameter int unsigned PAYOUT_JACKPOT  = slot_pkg::DEFAULT_PAYOUT_JACKPOT,
    parameter int unsigned SHOW_CYCLES     = 50_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input logic         clock,
    input logic         reset,
    slot_reel_judge_if.slave bus
);
    import slot_pkg::*;

    localparam int unsigned SUM_W  = CREDIT_W + 5;
    localparam int unsigned SHOW_W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;

    localparam logic [SUM_W-1:0] CREDIT_MAX  = {5'b0, {CREDIT_W{1'b1}}};
    localparam logic [SUM_W-1:0] PAY_PAIR    = SUM_W'(PAYOUT_PAIR);
    localparam logic [SUM_W-1:0] PAY_JACKPOT = SUM_W'(PAYOUT_JACKPOT);

    logic start_rise;
    logic stop_rise;

    state_e              state_q, state_d;
    logic                running_q, running_d;
    reel_t [2:0]         reel_q, reel_d;
    logic [2:0]          valid_q, valid_d;
    logic                win_q, win_d;
    logic                jackpot_q, jackpot_d;
    logic [CREDIT_W-1:0] credits_q, credits_d;
    logic [SHOW_W-1:0]   show_cnt_q, show_cnt_d;

    logic                deduct;
    logic [SUM_W-1:0]    payout;
    logic [SUM_W-1:0]    credit_sum;

    slot_btn_edge #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_start_edge (
        .clock(clock),
        .reset(reset),
        .level(bus.start_btn),
        .rise (start_rise)
    );

    slot_btn_edge #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_stop_edge (
        .clock(clock),
        .reset(reset),
        .level(bus.stop_btn),
        .rise (stop_rise)
    );

    always_comb begin
        state_d    = state_q;
        reel_d     = reel_q;
        valid_d    = valid_q;
        win_d      = win_q;
        jackpot_d  = jackpot_q;
        show_cnt_d = show_cnt_q;
        deduct     = 1'b0;
        payout     = '0;

        unique case (state_q)
            StIdle: begin
                // Funding check uses the balance before this cycle's coin.
                if (start_rise && credits_q != '0) begin
                    deduct    = 1'b1;
                    reel_d    = '0;
                    valid_d   = '0;
                    win_d     = 1'b0;
                    jackpot_d = 1'b0;
                    state_d   = StSpin0;
                end
            end
            StSpin0: begin
                if (stop_rise) begin
                    reel_d[0]  = bus.lfsr_in;
                    valid_d[0] = 1'b1;
                    state_d    = StSpin1;
                end
            end
            StSpin1: begin
                if (stop_rise) begin
                    reel_d[1]  = bus.lfsr_in;
                    valid_d[1] = 1'b1;
                    state_d    = StSpin2;
                end
            end
            StSpin2: begin
                if (stop_rise) begin
                    reel_d[2]  = bus.lfsr_in;
                    valid_d[2] = 1'b1;
                    state_d    = StJudge;
                end
            end
            StJudge: begin
                case (score_reels(reel_q[0], reel_q[1], reel_q[2]))
                    ScoreJackpot: begin
                        win_d     = 1'b1;
                        jackpot_d = 1'b1;
                        payout    = PAY_JACKPOT;
                    end
                    ScorePair: begin
                        win_d  = 1'b1;
                        payout = PAY_PAIR;
                    end
                    default: ;
                endcase
                show_cnt_d = '0;
                state_d    = StShow;
            end
            StShow: begin
                if (show_cnt_q == SHOW_W'(SHOW_CYCLES - 1)) begin
                    win_d     = 1'b0;
                    jackpot_d = 1'b0;
                    state_d   = StIdle;
                end else begin
                    show_cnt_d = show_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // deduct is only raised with credits >= 1, so the sum never goes negative.
    always_comb begin
        credit_sum = SUM_W'(credits_q) + SUM_W'(bus.coin) + payout - SUM_W'(deduct);
        credits_d  = (credit_sum > CREDIT_MAX) ? {CREDIT_W{1'b1}} : credit_sum[CREDIT_W-1:0];
    end

    assign running_d = (state_d == StSpin0) || (state_d == StSpin1) || (state_d == StSpin2);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            running_q  <= 1'b0;
            reel_q     <= '0;
            valid_q    <= '0;
            win_q      <= 1'b0;
            jackpot_q  <= 1'b0;
            credits_q  <= CREDIT_W'(INIT_CREDITS);
            show_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            running_q  <= running_d;
            reel_q     <= reel_d;
            valid_q    <= valid_d;
            win_q      <= win_d;
            jackpot_q  <= jackpot_d;
            credits_q  <= credits_d;
            show_cnt_q <= show_cnt_d;
        end
    end

    assign bus.running    = running_q;
    assign bus.reel0      = reel_q[0];
    assign bus.reel1      = reel_q[1];
    assign bus.reel2      = reel_q[2];
    assign bus.reel_valid = valid_q;
    assign bus.win        = win_q;
    assign bus.jackpot    = jackpot_q;
    assign bus.credits    = credits_q;

endmodule

// File: tb/tb_slot_reel_judge.sv
// Directed bench for slot_reel_judge: a per-cycle vector table on the default instance,
// plus hand sequences for held stop, zero credits and credit saturation.
module tb_slot_reel_judge;
    import slot_pkg::*;

    typedef struct {
        logic       rst;
        logic       st;
        logic       sp;
        logic       cn;
        reel_t      lf;
        logic       run;
        logic [2:0] val;
        logic       win;
        logic       jp;
        logic [7:0] cred;
        reel_t      r0;
        reel_t      r1;
        reel_t      r2;
    } vec_t;

    logic  clock = 1'b0;
    always #5 clock = ~clock;

    logic  rst_a, rst_z, rst_s;
    reel_t lfsr;
    logic  start_btn, stop_btn, coin;

    int    checks = 0;
    int    errors = 0;
    vec_t  vecs[$];

    slot_reel_judge_if #(.CREDIT_W(8)) bus_a ();
    slot_reel_judge_if #(.CREDIT_W(8)) bus_z ();
    slot_reel_judge_if #(.CREDIT_W(4)) bus_s ();

    assign bus_a.lfsr_in = lfsr;
    assign bus_a.start_btn = start_btn;
    assign bus_a.stop_btn = stop_btn;
    assign bus_a.coin = coin;
    assign bus_z.lfsr_in = lfsr;
    assign bus_z.start_btn = start_btn;
    assign bus_z.stop_btn = stop_btn;
    assign bus_z.coin = coin;
    assign bus_s.lfsr_in = lfsr;
    assign bus_s.start_btn = start_btn;
    assign bus_s.stop_btn = stop_btn;
    assign bus_s.coin = coin;

    slot_reel_judge #(
        .CREDIT_W(8), .INIT_CREDITS(3), .PAYOUT_PAIR(2), .PAYOUT_JACKPOT(10),
        .SHOW_CYCLES(3), .DEBOUNCE_CYCLES(16)
    ) dut_a (
        .clock(clock), .reset(rst_a), .bus(bus_a.slave)
    );

    slot_reel_judge #(
        .CREDIT_W(8), .INIT_CREDITS(0), .PAYOUT_PAIR(2), .PAYOUT_JACKPOT(10),
        .SHOW_CYCLES(3), .DEBOUNCE_CYCLES(16)
    ) dut_z (
        .clock(clock), .reset(rst_z), .bus(bus_z.slave)
    );

    slot_reel_judge #(
        .CREDIT_W(4), .INIT_CREDITS(14), .PAYOUT_PAIR(2), .PAYOUT_JACKPOT(10),
        .SHOW_CYCLES(3), .DEBOUNCE_CYCLES(16)
    ) dut_s (
        .clock(clock), .reset(rst_s), .bus(bus_s.slave)
    );

    function automatic void add(logic rst, logic st, logic sp, logic cn, reel_t lf, logic run,
                                logic [2:0] val, logic win, logic jp, logic [7:0] cred,
                                reel_t r0, reel_t r1, reel_t r2);
        vec_t v;
        v.rst = rst; v.st = st; v.sp = sp; v.cn = cn; v.lf = lf;
        v.run = run; v.val = val; v.win = win; v.jp = jp; v.cred = cred;
        v.r0 = r0; v.r1 = r1; v.r2 = r2;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Drive inputs on the falling edge, then sample just after the next rising edge.
    task automatic step(input logic st, input logic sp, input logic cn, input reel_t lf);
        @(negedge clock);
        start_btn = st;
        stop_btn  = sp;
        coin      = cn;
        lfsr      = lf;
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [63:0] got, exp;

        rst_a = 1'b1; rst_z = 1'b1; rst_s = 1'b1;
        start_btn = 1'b0; stop_btn = 1'b0; coin = 1'b0; lfsr = '0;

        //   rst st sp cn lf   run val     w  j  cred  r0 r1 r2
        add(1, 0, 0, 0, 0,  0, 3'b000, 0, 0, 3,   0, 0, 0);  // 0 reset
        add(0, 0, 0, 0, 0,  0, 3'b000, 0, 0, 3,   0, 0, 0);
        add(0, 1, 0, 0, 0,  1, 3'b000, 0, 0, 2,   0, 0, 0);  // start accepted
        add(0, 1, 0, 0, 0,  1, 3'b000, 0, 0, 2,   0, 0, 0);
        add(0, 0, 1, 0, 5,  1, 3'b001, 0, 0, 2,   5, 0, 0);
        add(0, 0, 0, 0, 7,  1, 3'b001, 0, 0, 2,   5, 0, 0);
        add(0, 0, 1, 0, 5,  1, 3'b011, 0, 0, 2,   5, 5, 0);
        add(0, 0, 0, 0, 0,  1, 3'b011, 0, 0, 2,   5, 5, 0);
        add(0, 0, 1, 0, 5,  0, 3'b111, 0, 0, 2,   5, 5, 5);  // reel2 -> judge
        add(0, 0, 0, 0, 0,  0, 3'b111, 1, 1, 12,  5, 5, 5);  // jackpot
        add(0, 1, 0, 0, 0,  0, 3'b111, 1, 1, 12,  5, 5, 5);  // start ignored in show
        add(0, 0, 0, 0, 0,  0, 3'b111, 1, 1, 12,  5, 5, 5);
        add(0, 0, 0, 0, 0,  0, 3'b111, 0, 0, 12,  5, 5, 5);  // back to idle
        add(1, 0, 0, 0, 0,  0, 3'b000, 0, 0, 3,   0, 0, 0);  // 13 reset
        add(0, 1, 0, 0, 0,  1, 3'b000, 0, 0, 2,   0, 0, 0);
        add(0, 0, 1, 0, 5,  1, 3'b001, 0, 0, 2,   5, 0, 0);
        add(0, 0, 0, 0, 0,  1, 3'b001, 0, 0, 2,   5, 0, 0);
        add(0, 0, 1, 0, 5,  1, 3'b011, 0, 0, 2,   5, 5, 0);
        add(0, 0, 0, 0, 0,  1, 3'b011, 0, 0, 2,   5, 5, 0);
        add(0, 0, 1, 0, 9,  0, 3'b111, 0, 0, 2,   5, 5, 9);
        add(0, 0, 0, 0, 0,  0, 3'b111, 1, 0, 4,   5, 5, 9);  // pair
        add(0, 0, 0, 0, 0,  0, 3'b111, 1, 0, 4,   5, 5, 9);
        add(0, 0, 0, 0, 0,  0, 3'b111, 1, 0, 4,   5, 5, 9);
        add(0, 0, 0, 0, 0,  0, 3'b111, 0, 0, 4,   5, 5, 9);
        add(0, 1, 0, 0, 0,  1, 3'b000, 0, 0, 3,   0, 0, 0);  // 24 miss round
        add(0, 0, 1, 0, 1,  1, 3'b001, 0, 0, 3,   1, 0, 0);
        add(0, 0, 1, 0, 2,  1, 3'b001, 0, 0, 3,   1, 0, 0);  // held stop: no edge
        add(0, 0, 0, 0, 0,  1, 3'b001, 0, 0, 3,   1, 0, 0);
        add(0, 0, 1, 0, 2,  1, 3'b011, 0, 0, 3,   1, 2, 0);
        add(0, 0, 0, 0, 0,  1, 3'b011, 0, 0, 3,   1, 2, 0);
        add(0, 0, 1, 0, 3,  0, 3'b111, 0, 0, 3,   1, 2, 3);
        add(0, 0, 0, 0, 0,  0, 3'b111, 0, 0, 3,   1, 2, 3);  // miss
        add(0, 0, 0, 0, 0,  0, 3'b111, 0, 0, 3,   1, 2, 3);
        add(0, 0, 0, 0, 0,  0, 3'b111, 0, 0, 3,   1, 2, 3);
        add(0, 0, 0, 1, 0,  0, 3'b111, 0, 0, 4,   1, 2, 3);  // coin in idle
        add(0, 1, 0, 0, 0,  1, 3'b000, 0, 0, 3,   0, 0, 0);  // 35
        add(0, 0, 1, 0, 6,  1, 3'b001, 0, 0, 3,   6, 0, 0);
        add(0, 0, 0, 0, 0,  1, 3'b001, 0, 0, 3,   6, 0, 0);  // in SPIN1
        add(1, 0, 0, 0, 0,  0, 3'b000, 0, 0, 3,   0, 0, 0);  // reset mid-round
        add(0, 0, 0, 0, 0,  0, 3'b000, 0, 0, 3,   0, 0, 0);
        add(0, 1, 0, 0, 0,  1, 3'b000, 0, 0, 2,   0, 0, 0);  // 40

        repeat (2) @(posedge clock);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clock);
            rst_a     = vecs[i].rst;
            start_btn = vecs[i].st;
            stop_btn  = vecs[i].sp;
            coin      = vecs[i].cn;
            lfsr      = vecs[i].lf;
            @(posedge clock);
            #1;
            got = 64'({bus_a.running, bus_a.reel_valid, bus_a.win, bus_a.jackpot, bus_a.credits,
                       bus_a.reel0, bus_a.reel1, bus_a.reel2});
            exp = 64'({vecs[i].run, vecs[i].val, vecs[i].win, vecs[i].jp, vecs[i].cred,
                       vecs[i].r0, vecs[i].r1, vecs[i].r2});
            check($sformatf("vec%0d", i), got, exp);
        end

        // Stop held high from the SPIN0 edge: only reel0 is captured.
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, 1'b0, reel_t'(4 + i));
        end
        check("held_stop_valid", 64'(bus_a.reel_valid), 64'(3'b001));
        check("held_stop_reel0", 64'(bus_a.reel0), 64'(4'd4));
        check("held_stop_running", 64'(bus_a.running), 64'(1'b1));

        // Zero credits.
        rst_a = 1'b1;
        step(1'b0, 1'b0, 1'b0, 4'd0);
        rst_z = 1'b0;
        step(1'b1, 1'b0, 1'b0, 4'd0);
        check("zero_start_running", 64'(bus_z.running), 64'(1'b0));
        check("zero_start_credits", 64'(bus_z.credits), 64'(8'd0));
        step(1'b0, 1'b0, 1'b0, 4'd0);
        step(1'b1, 1'b0, 1'b1, 4'd0);
        check("coin_start_running", 64'(bus_z.running), 64'(1'b0));
        check("coin_start_credits", 64'(bus_z.credits), 64'(8'd1));
        step(1'b0, 1'b0, 1'b0, 4'd0);
        step(1'b1, 1'b0, 1'b0, 4'd0);
        check("funded_start_running", 64'(bus_z.running), 64'(1'b1));
        check("funded_start_credits", 64'(bus_z.credits), 64'(8'd0));

        // Saturation at 4 bits.
        rst_z = 1'b1;
        step(1'b0, 1'b0, 1'b0, 4'd0);
        rst_s = 1'b0;
        step(1'b1, 1'b0, 1'b0, 4'd0);
        check("sat_start_credits", 64'(bus_s.credits), 64'(4'd13));
        step(1'b0, 1'b1, 1'b0, 4'd5);
        step(1'b0, 1'b0, 1'b0, 4'd0);
        step(1'b0, 1'b1, 1'b0, 4'd5);
        step(1'b0, 1'b0, 1'b0, 4'd0);
        step(1'b0, 1'b1, 1'b0, 4'd5);
        check("sat_valid", 64'({bus_s.running, bus_s.reel_valid}), 64'(4'b0111));
        step(1'b0, 1'b0, 1'b1, 4'd0);
        check("sat_judge_credits", 64'(bus_s.credits), 64'(4'd15));
        check("sat_judge_flags", 64'({bus_s.win, bus_s.jackpot}), 64'(2'b11));
        step(1'b0, 1'b0, 1'b1, 4'd0);
        check("sat_coin_credits", 64'(bus_s.credits), 64'(4'd15));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
